// File: rtl/test_encoder_if.sv
// rtl/test_encoder_if.sv - input/output handshake bundle for test_encoder
interface test_encoder_if;
    logic [7:0]  data_in;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] out_codeword;
    logic        out_valid;
    logic        out_ready;

    modport master (
        output data_in, in_valid, out_ready,
        input  in_ready, out_codeword, out_valid
    );

    modport slave (
        input  data_in, in_valid, out_ready,
        output in_ready, out_codeword, out_valid
    );
endinterface

// File: rtl/test_encoder.sv
// rtl/test_encoder.sv - tags bytes into 12-bit codewords through a 2-entry FIFO; TEST_ENCODER_CHECK_EN adds a combinational tag checker
module test_encoder #(
    parameter logic [3:0] TAG   = 4'b1010,
    parameter int         CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    test_encoder_if.slave    enc,
    output logic [11:0]      codeword,
    output logic [CNT_W-1:0] word_cnt
`ifdef TEST_ENCODER_CHECK_EN
    ,
    input  logic [11:0]      chk_codeword,
    output logic [7:0]       chk_data,
    output logic             chk_err
`endif
);

    logic [11:0] mem [2];
    logic        rd_ptr;
    logic        wr_ptr;
    logic [1:0]  count;
    logic        push;
    logic        pop;

    assign codeword = {enc.data_in, TAG};

    // Ready depends only on registered occupancy so it never combinationally follows in_valid/out_ready.
    assign enc.in_ready     = rst_n && (count < 2'd2);
    assign enc.out_valid    = (count != 2'd0);
    assign enc.out_codeword = enc.out_valid ? mem[rd_ptr] : 12'h000;

    assign push = enc.in_valid && enc.in_ready;
    assign pop  = enc.out_valid && enc.out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem[0]   <= 12'h000;
            mem[1]   <= 12'h000;
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
            count    <= 2'd0;
            word_cnt <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= codeword;
                wr_ptr      <= ~wr_ptr;
                word_cnt    <= word_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

`ifdef TEST_ENCODER_CHECK_EN
    assign chk_data = chk_codeword[11:4];
    assign chk_err  = (chk_codeword[3:0] != TAG);
`endif

endmodule

// File: tb/tb_test_encoder.sv
// tb/tb_test_encoder.sv - directed self-checking bench for test_encoder
module tb_test_encoder;
    localparam int CNT_W = 4;

    logic             clk;
    logic             rst_n;
    logic [11:0]      codeword;
    logic [CNT_W-1:0] word_cnt;
    int               tests;
    int               fails;

    test_encoder_if enc ();

`ifdef TEST_ENCODER_CHECK_EN
    logic [11:0] chk_codeword;
    logic [7:0]  chk_data;
    logic        chk_err;
`endif

    test_encoder #(
        .TAG   (4'b1010),
        .CNT_W (CNT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enc          (enc.slave),
        .codeword     (codeword),
        .word_cnt     (word_cnt)
`ifdef TEST_ENCODER_CHECK_EN
        ,
        .chk_codeword (chk_codeword),
        .chk_data     (chk_data),
        .chk_err      (chk_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        enc.in_valid  = 1'b0;
        enc.out_ready = 1'b0;
        enc.data_in   = 8'b10101010;
        #1;
        check("comb_codeword_no_clock", 32'(codeword), 32'hAAA);
        check("in_ready_in_reset", 32'(enc.in_ready), 32'h0);
        step();
        step();
        check("rst_out_valid", 32'(enc.out_valid), 32'h0);
        check("rst_out_codeword", 32'(enc.out_codeword), 32'h000);
        check("rst_word_cnt", 32'(word_cnt), 32'h0);

        rst_n = 1'b1;
        #1;
        check("in_ready_after_release", 32'(enc.in_ready), 32'h1);

        // single word, one-edge latency
        enc.data_in = 8'h3C; enc.in_valid = 1'b1; enc.out_ready = 1'b1;
        step();
        enc.in_valid = 1'b0;
        check("lat_out_valid", 32'(enc.out_valid), 32'h1);
        check("lat_out_codeword", 32'(enc.out_codeword), 32'h3CA);
        check("lat_word_cnt", 32'(word_cnt), 32'h1);
        step();
        check("drain_empty", 32'(enc.out_valid), 32'h0);

        // fill to full, third push ignored, then drain in order
        enc.out_ready = 1'b0;
        enc.data_in = 8'h11; enc.in_valid = 1'b1; step();
        enc.data_in = 8'h22; step();
        check("full_in_ready", 32'(enc.in_ready), 32'h0);
        enc.data_in = 8'h33; step();
        check("hold_head", 32'(enc.out_codeword), 32'h11A);
        check("ignored_push_cnt", 32'(word_cnt), 32'h3);
        enc.in_valid = 1'b0; enc.out_ready = 1'b1;
        step();
        check("order_second", 32'(enc.out_codeword), 32'h22A);
        step();
        check("order_empty", 32'(enc.out_valid), 32'h0);
        check("empty_codeword_zero", 32'(enc.out_codeword), 32'h000);

        // simultaneous push and pop at occupancy 1
        enc.out_ready = 1'b0;
        enc.data_in = 8'h44; enc.in_valid = 1'b1; step();
        check("one_entry_head", 32'(enc.out_codeword), 32'h44A);
        enc.data_in = 8'h55; enc.out_ready = 1'b1; step();
        check("pushpop_head", 32'(enc.out_codeword), 32'h55A);
        check("pushpop_in_ready", 32'(enc.in_ready), 32'h1);
        enc.in_valid = 1'b0; step();
        check("pushpop_occ_one", 32'(enc.out_valid), 32'h0);

        // full with out_ready=1 still refuses input
        enc.out_ready = 1'b0; enc.in_valid = 1'b1;
        enc.data_in = 8'h66; step();
        enc.data_in = 8'h77; step();
        enc.data_in = 8'h88; enc.out_ready = 1'b1;
        #1;
        check("full_ready_with_pop", 32'(enc.in_ready), 32'h0);
        step();
        check("full_pop_head", 32'(enc.out_codeword), 32'h77A);
        check("full_pop_cnt", 32'(word_cnt), 32'h7);

        // streaming push+pop until the 4-bit counter wraps
        enc.in_valid = 1'b0; step();
        check("before_stream_empty", 32'(enc.out_valid), 32'h0);
        enc.in_valid = 1'b1; enc.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            enc.data_in = 8'h90 + 8'(i);
            step();
        end
        check("cnt_all_ones", 32'(word_cnt), 32'hF);
        enc.data_in = 8'h98; step();
        check("cnt_wrap", 32'(word_cnt), 32'h0);
        check("stream_head", 32'(enc.out_codeword), 32'h98A);

        // reset mid-stream discards buffered words
        rst_n = 1'b0; enc.data_in = 8'h5E;
        #1;
        check("midrst_in_ready", 32'(enc.in_ready), 32'h0);
        step();
        check("midrst_out_valid", 32'(enc.out_valid), 32'h0);
        check("midrst_out_codeword", 32'(enc.out_codeword), 32'h000);
        check("midrst_word_cnt", 32'(word_cnt), 32'h0);
        check("midrst_codeword", 32'(codeword), 32'h5EA);
        enc.in_valid = 1'b0;
        rst_n = 1'b1;
        #1;
        check("midrst_release_ready", 32'(enc.in_ready), 32'h1);

`ifdef TEST_ENCODER_CHECK_EN
        chk_codeword = 12'hA5A;
        #1;
        check("chk_data", 32'(chk_data), 32'hA5);
        check("chk_err_ok", 32'(chk_err), 32'h0);
        chk_codeword = 12'hA5B;
        #1;
        check("chk_err_bad", 32'(chk_err), 32'h1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/test_encoder.md
TEST_ENCODER -- requirements
Module: test_encoder

Interface
REQ-001 SHALL have parameter TAG, default 4'b1010, meaning the constant tag placed in codeword[3:0].
REQ-002 SHALL have parameter CNT_W, default 16, meaning the width of the accepted-word counter.
REQ-003 SHALL have a single clock and a synchronous, active-low reset; no other clocks or resets.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  synchronous reset, active low.
REQ-006 data_in  input  8  data byte to encode.
REQ-007 codeword  output  12  combinational encoding of data_in.
REQ-008 in_valid  input  1  data_in is offered for the registered path.
REQ-009 in_ready  output  1  the block can accept data_in this cycle.
REQ-010 out_codeword  output  12  registered codeword at the head of the output buffer.
REQ-011 out_valid  output  1  out_codeword holds a valid word.
REQ-012 out_ready  input  1  the downstream block consumes out_codeword this cycle.
REQ-013 word_cnt  output  CNT_W  count of accepted input words.

Function
REQ-014 codeword SHALL equal {data_in, TAG}, purely combinational, valid in the same delta with no clock edge and unaffected by reset.
REQ-015 An input transfer SHALL occur on a rising edge when in_valid=1 and in_ready=1; the stored word is {data_in, TAG}.
REQ-016 A 2-entry FIFO SHALL hold encoded words; in_ready = (occupancy < 2) and rst_n=1, computed from registered occupancy only.
REQ-017 Latency: a word accepted at edge N into an empty FIFO SHALL appear on out_codeword with out_valid=1 after edge N.
REQ-018 An output transfer SHALL occur when out_valid=1 and out_ready=1; the head is popped at that edge.
REQ-019 Push and pop in the same cycle SHALL leave occupancy unchanged and preserve order; when full, in_ready=0 even if out_ready=1.
REQ-020 out_codeword SHALL hold its value while out_valid=1 and out_ready=0; when empty it SHALL hold 12'h000.
REQ-021 word_cnt SHALL increment by 1 per input transfer and wrap from all-ones to 0.
REQ-022 in_valid while in_ready=0 SHALL be ignored, with no state change.

Reset
REQ-023 While rst_n=0 at a rising edge: occupancy=0, out_valid=0, out_codeword=12'h000, word_cnt=0, and FIFO contents are cleared.
REQ-024 in_ready SHALL be 0 while rst_n=0 and SHALL be 1 in the first cycle after release.
REQ-025 Reset asserted mid-operation SHALL discard all buffered words at that edge; codeword is unaffected.

Configuration
REQ-026 Macro TEST_ENCODER_CHECK_EN: when defined, the block SHALL add input chk_codeword[11:0], output chk_data[7:0]=chk_codeword[11:4], and output chk_err=(chk_codeword[3:0]!=TAG), all combinational.
REQ-027 When TEST_ENCODER_CHECK_EN is undefined, these ports and their logic SHALL be absent; all other behaviour is identical.

Verification
REQ-028 data_in=8'b10101010, no clock -> codeword=12'b101010101010 immediately.
REQ-029 Reset, then in_valid=1, data_in=8'h3C, out_ready=1 for one cycle -> next cycle out_valid=1, out_codeword=12'h3CA, word_cnt=1.
REQ-030 out_ready=0, push 8'h11, 8'h22 -> in_ready=0 after 2 pushes; a third push is ignored; then out_ready=1 -> 12'h11A, then 12'h22A, then out_valid=0.
REQ-031 Fill to 1 entry, then push 8'h55 with out_ready=1 simultaneously -> occupancy stays 1 and out_codeword becomes 12'h55A.
REQ-032 word_cnt preloaded to all-ones via 2^CNT_W transfers (or CNT_W=4 with 16 transfers) -> wraps to 0; reset mid-stream -> out_valid=0, word_cnt=0.
REQ-033 With TEST_ENCODER_CHECK_EN defined: chk_codeword=12'hA5A -> chk_data=8'hA5, chk_err=0; chk_codeword=12'hA5B -> chk_err=1.
